// File: rtl/clock_set_ctrl.sv
`timescale 1ns/1ps
// clock_set_ctrl
// Button-driven set-mode controller for a clock display. Mode steps
// RUN -> SET_HOUR -> SET_MIN -> RUN. Up/Down produce single-cycle adjust
// pulses for the field being set. An idle timeout returns the controller to
// RUN, and a blink phase requests blanking of the field being set.
//
// Optional feature: define CLOCK_SET_CTRL_AUTO_REPEAT_EN to let a held
// Up/Down auto-repeat (first repeat after HOLD_CYC, then every REPEAT_CYC).
//
// Ports:
//   iClk        system clock, rising edge
//   iRst        asynchronous active-high reset
//   iBtn_Mode   debounced Mode button level
//   iBtn_Up     debounced Up button level
//   iBtn_Down   debounced Down button level
//   oSet        high in SET_HOUR / SET_MIN
//   oHour_Up, oHour_Down, oMin_Up, oMin_Down   single-cycle adjust pulses
//   oMode       00 RUN, 01 SET_HOUR, 10 SET_MIN
//   oBlink_Hour, oBlink_Min   blank request for the field being set
module clock_set_ctrl #(
    parameter int unsigned HOLD_CYC    = 50_000_000,
    parameter int unsigned REPEAT_CYC  = 10_000_000,
    parameter int unsigned TIMEOUT_CYC = 1_000_000_000,
    parameter int unsigned BLINK_CYC   = 25_000_000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iBtn_Mode,
    input  logic       iBtn_Up,
    input  logic       iBtn_Down,
    output logic       oSet,
    output logic       oHour_Up,
    output logic       oHour_Down,
    output logic       oMin_Up,
    output logic       oMin_Down,
    output logic [1:0] oMode,
    output logic       oBlink_Hour,
    output logic       oBlink_Min
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST  = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_CYC - 1);

`ifdef CLOCK_SET_CTRL_AUTO_REPEAT_EN
    localparam logic AUTO_REPEAT = 1'b1;
`else
    localparam logic AUTO_REPEAT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOUR = 2'b01,
        ST_MIN  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_armed;
    logic             r_mode_prev;
    logic             r_up_prev;
    logic             r_down_prev;

    logic [CNT_W-1:0] r_idle;
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_phase;
    logic [CNT_W-1:0] w_blink_cnt_nxt;
    logic             w_phase_nxt;

    logic             r_rep_active;
    logic             r_rep_first;
    logic             r_rep_up;
    logic [CNT_W-1:0] r_rep_cnt;

    logic             r_set;
    logic [1:0]       r_mode;
    logic             r_hour_up;
    logic             r_hour_down;
    logic             r_min_up;
    logic             r_min_down;
    logic             r_blink_hour;
    logic             r_blink_min;

    logic             w_set_nxt;
    logic             w_hour_up_nxt;
    logic             w_hour_down_nxt;
    logic             w_min_up_nxt;
    logic             w_min_down_nxt;
    logic             w_blink_hour_nxt;
    logic             w_blink_min_nxt;

    // Edge detection; r_armed masks the first cycle after reset so a button
    // held through reset is not mistaken for a fresh press.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_armed     <= 1'b0;
            r_mode_prev <= 1'b0;
            r_up_prev   <= 1'b0;
            r_down_prev <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_mode_prev <= iBtn_Mode;
            r_up_prev   <= iBtn_Up;
            r_down_prev <= iBtn_Down;
        end
    end

    logic w_mode_rise, w_up_rise, w_down_rise, w_any_rise;
    logic w_in_set, w_adj_en, w_up_press, w_down_press;
    logic w_rep_held, w_rep_fire;
    logic w_up_req, w_down_req, w_any_pulse, w_timeout, w_state_chg;
    logic [CNT_W-1:0] w_rep_target;

    assign w_mode_rise = r_armed & iBtn_Mode & ~r_mode_prev;
    assign w_up_rise   = r_armed & iBtn_Up   & ~r_up_prev;
    assign w_down_rise = r_armed & iBtn_Down & ~r_down_prev;
    assign w_any_rise  = w_mode_rise | w_up_rise | w_down_rise;

    // A Mode edge wins over any adjust in the same cycle.
    assign w_in_set = (r_state != ST_RUN);
    assign w_adj_en = w_in_set & ~w_mode_rise;

    // A new edge counts only while the opposite button is low; this also
    // rejects simultaneous Up+Down edges.
    assign w_up_press   = w_up_rise   & ~iBtn_Down;
    assign w_down_press = w_down_rise & ~iBtn_Up;

    assign w_rep_target = r_rep_first ? HOLD_LAST : REPEAT_LAST;
    assign w_rep_held   = r_rep_up ? (iBtn_Up & ~iBtn_Down) : (iBtn_Down & ~iBtn_Up);
    assign w_rep_fire   = AUTO_REPEAT & r_rep_active & w_rep_held & w_adj_en
                        & (r_rep_cnt == w_rep_target);

    assign w_up_req    = w_adj_en & (w_up_press   | (w_rep_fire &  r_rep_up));
    assign w_down_req  = w_adj_en & (w_down_press | (w_rep_fire & ~r_rep_up));
    assign w_any_pulse = w_up_req | w_down_req;

    assign w_timeout   = w_in_set & ~w_any_rise & ~w_any_pulse & (r_idle == TIMEOUT_LAST);
    assign w_state_chg = (w_next != r_state);

    // FSM state register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        if (w_mode_rise) begin
            case (r_state)
                ST_RUN:  w_next = ST_HOUR;
                ST_HOUR: w_next = ST_MIN;
                default: w_next = ST_RUN;
            endcase
        end else if (w_timeout) begin
            w_next = ST_RUN;
        end
    end

    // FSM output logic (next values for the output registers)
    always_comb begin
        w_set_nxt        = 1'b0;
        w_hour_up_nxt    = 1'b0;
        w_hour_down_nxt  = 1'b0;
        w_min_up_nxt     = 1'b0;
        w_min_down_nxt   = 1'b0;
        w_blink_hour_nxt = 1'b0;
        w_blink_min_nxt  = 1'b0;
        w_set_nxt        = (w_next != ST_RUN);
        if (r_state == ST_HOUR) begin
            w_hour_up_nxt   = w_up_req;
            w_hour_down_nxt = w_down_req;
        end
        if (r_state == ST_MIN) begin
            w_min_up_nxt    = w_up_req;
            w_min_down_nxt  = w_down_req;
        end
        w_blink_hour_nxt = w_phase_nxt & (w_next == ST_HOUR);
        w_blink_min_nxt  = w_phase_nxt & (w_next == ST_MIN);
    end

    // Output registers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_set        <= 1'b0;
            r_mode       <= 2'b00;
            r_hour_up    <= 1'b0;
            r_hour_down  <= 1'b0;
            r_min_up     <= 1'b0;
            r_min_down   <= 1'b0;
            r_blink_hour <= 1'b0;
            r_blink_min  <= 1'b0;
        end else begin
            r_set        <= w_set_nxt;
            r_mode       <= w_next;
            r_hour_up    <= w_hour_up_nxt;
            r_hour_down  <= w_hour_down_nxt;
            r_min_up     <= w_min_up_nxt;
            r_min_down   <= w_min_down_nxt;
            r_blink_hour <= w_blink_hour_nxt;
            r_blink_min  <= w_blink_min_nxt;
        end
    end

    // Blink phase: restarts visible on any state change or adjust.
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt + CNT_W'(1);
        w_phase_nxt     = r_phase;
        if (w_state_chg || w_any_pulse) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
        end
    end

    // Idle and blink counters
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_idle      <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
            if (w_next == ST_RUN || w_state_chg || w_any_rise || w_any_pulse) begin
                r_idle <= '0;
            end else if (r_idle != TIMEOUT_LAST) begin
                r_idle <= r_idle + CNT_W'(1);
            end
        end
    end

    // Auto-repeat tracker; never arms unless the feature is built in.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_rep_active <= 1'b0;
            r_rep_first  <= 1'b0;
            r_rep_up     <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (AUTO_REPEAT && w_adj_en && (w_up_press || w_down_press)) begin
            r_rep_active <= 1'b1;
            r_rep_first  <= 1'b1;
            r_rep_up     <= w_up_press;
            r_rep_cnt    <= '0;
        end else if (!r_rep_active || !w_rep_held || !w_adj_en || w_state_chg) begin
            r_rep_active <= 1'b0;
            r_rep_first  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_rep_fire) begin
            r_rep_first  <= 1'b0;
            r_rep_cnt    <= '0;
        end else begin
            r_rep_cnt    <= r_rep_cnt + CNT_W'(1);
        end
    end

    assign oSet        = r_set;
    assign oMode       = r_mode;
    assign oHour_Up    = r_hour_up;
    assign oHour_Down  = r_hour_down;
    assign oMin_Up     = r_min_up;
    assign oMin_Down   = r_min_down;
    assign oBlink_Hour = r_blink_hour;
    assign oBlink_Min  = r_blink_min;

endmodule

// File: tb/tb_clock_set_ctrl.sv
`timescale 1ns/1ps
module tb_clock_set_ctrl;

    localparam int unsigned HOLD    = 8;
    localparam int unsigned REPEAT  = 4;
    localparam int unsigned TIMEOUT = 50;
    localparam int unsigned BLINK   = 5;
    localparam int NVEC = 36;

`ifdef CLOCK_SET_CTRL_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iBtn_Mode = 1'b0;
    logic       iBtn_Up = 1'b0;
    logic       iBtn_Down = 1'b0;
    logic       oSet, oHour_Up, oHour_Down, oMin_Up, oMin_Down;
    logic [1:0] oMode;
    logic       oBlink_Hour, oBlink_Min;

    clock_set_ctrl #(
        .HOLD_CYC   (HOLD),
        .REPEAT_CYC (REPEAT),
        .TIMEOUT_CYC(TIMEOUT),
        .BLINK_CYC  (BLINK)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iBtn_Mode  (iBtn_Mode),
        .iBtn_Up    (iBtn_Up),
        .iBtn_Down  (iBtn_Down),
        .oSet       (oSet),
        .oHour_Up   (oHour_Up),
        .oHour_Down (oHour_Down),
        .oMin_Up    (oMin_Up),
        .oMin_Down  (oMin_Down),
        .oMode      (oMode),
        .oBlink_Hour(oBlink_Hour),
        .oBlink_Min (oBlink_Min)
    );

    always #5 iClk = ~iClk;

    // in = {mode, up, down}; exp = {oMode, oSet, hu, hd, mu, md, bh, bm}
    typedef struct {
        logic [2:0] in;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[NVEC];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(input logic [2:0] in, input logic [8:0] exp);
        vec_t r;
        r.in  = in;
        r.exp = exp;
        return r;
    endfunction

    function automatic logic [8:0] outs();
        return {oMode, oSet, oHour_Up, oHour_Down, oMin_Up, oMin_Down, oBlink_Hour, oBlink_Min};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = v(3'b000, 9'b00_0_0000_00);
        vecs[1]  = v(3'b100, 9'b01_1_0000_00);
        vecs[2]  = v(3'b000, 9'b01_1_0000_00);
        vecs[3]  = v(3'b010, 9'b01_1_1000_00);
        vecs[4]  = v(3'b010, 9'b01_1_0000_00);
        vecs[5]  = v(3'b000, 9'b01_1_0000_00);
        vecs[6]  = v(3'b000, 9'b01_1_0000_00);
        vecs[7]  = v(3'b000, 9'b01_1_0000_00);
        vecs[8]  = v(3'b000, 9'b01_1_0000_10);
        vecs[9]  = v(3'b001, 9'b01_1_0100_00);
        vecs[10] = v(3'b000, 9'b01_1_0000_00);
        vecs[11] = v(3'b100, 9'b10_1_0000_00);
        vecs[12] = v(3'b000, 9'b10_1_0000_00);
        vecs[13] = v(3'b010, 9'b10_1_0010_00);
        vecs[14] = v(3'b010, 9'b10_1_0000_00);
        vecs[15] = v(3'b000, 9'b10_1_0000_00);
        vecs[16] = v(3'b011, 9'b10_1_0000_00);
        vecs[17] = v(3'b000, 9'b10_1_0000_00);
        vecs[18] = v(3'b000, 9'b10_1_0000_01);
        vecs[19] = v(3'b010, 9'b10_1_0010_00);
        vecs[20] = v(3'b011, 9'b10_1_0000_00);
        vecs[21] = v(3'b000, 9'b10_1_0000_00);
        vecs[22] = v(3'b001, 9'b10_1_0001_00);
        vecs[23] = v(3'b000, 9'b10_1_0000_00);
        vecs[24] = v(3'b100, 9'b00_0_0000_00);
        vecs[25] = v(3'b010, 9'b00_0_0000_00);
        vecs[26] = v(3'b000, 9'b00_0_0000_00);
        vecs[27] = v(3'b001, 9'b00_0_0000_00);
        vecs[28] = v(3'b000, 9'b00_0_0000_00);
        vecs[29] = v(3'b000, 9'b00_0_0000_00);
        vecs[30] = v(3'b100, 9'b01_1_0000_00);
        vecs[31] = v(3'b000, 9'b01_1_0000_00);
        vecs[32] = v(3'b110, 9'b10_1_0000_00);
        vecs[33] = v(3'b000, 9'b10_1_0000_00);
        vecs[34] = v(3'b100, 9'b00_0_0000_00);
        vecs[35] = v(3'b000, 9'b00_0_0000_00);

        // Reset state
        iRst = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        check("reset_outs", 32'(outs()), 32'h0);
        iRst = 1'b0;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            {iBtn_Mode, iBtn_Up, iBtn_Down} = vecs[i].in;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Long Up hold in SET_HOUR: auto-repeat cadence (or a single pulse)
        iBtn_Mode = 1'b1; tick(); iBtn_Mode = 1'b0; tick();
        check("hold_enter_hour", 32'(oMode), 32'd1);
        iBtn_Up = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            logic e;
            tick();
            e = (k == 1) || (REP && k >= 9 && k <= 29 && ((k - 9) % 4 == 0));
            check($sformatf("hold_c%0d", k),
                  32'({oHour_Up, oHour_Down, oMin_Up, oMin_Down}), 32'({e, 3'b000}));
            if (k == 30) iBtn_Up = 1'b0;
        end
        iBtn_Mode = 1'b1; tick(); iBtn_Mode = 1'b0; tick();
        iBtn_Mode = 1'b1; tick(); iBtn_Mode = 1'b0; tick();
        check("hold_back_run", 32'(oMode), 32'd0);

        // Idle timeout from SET_HOUR
        iBtn_Mode = 1'b1; tick(); iBtn_Mode = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            tick();
            if (j == 49) check("tmo_before", 32'({oMode, oSet}), 32'({2'b01, 1'b1}));
            if (j == 50) check("tmo_expire", 32'({oMode, oSet}), 32'({2'b00, 1'b0}));
        end

        // Up press at cycle 40 restarts the timeout
        iBtn_Mode = 1'b1; tick(); iBtn_Mode = 1'b0;
        for (int j = 1; j <= 90; j++) begin
            if (j == 40) iBtn_Up = 1'b1;
            if (j == 41) iBtn_Up = 1'b0;
            tick();
            if (j == 40) check("tmo_press_pulse", 32'(oHour_Up), 32'd1);
            if (j == 50) check("tmo_restart_c50", 32'(oMode), 32'd1);
            if (j == 89) check("tmo_restart_c89", 32'({oMode, oSet}), 32'({2'b01, 1'b1}));
            if (j == 90) check("tmo_restart_c90", 32'({oMode, oSet}), 32'({2'b00, 1'b0}));
        end

        // Asynchronous reset mid-hold in SET_MIN, buttons held through reset
        iBtn_Mode = 1'b1; tick(); iBtn_Mode = 1'b0; tick();
        iBtn_Mode = 1'b1; tick(); iBtn_Mode = 1'b0; tick();
        iBtn_Up = 1'b1; tick();
        check("rst_pre_pulse", 32'(outs()), 32'(9'b10_1_0010_00));
        #3;
        iRst = 1'b1;
        iBtn_Mode = 1'b1;
        #1;
        check("rst_async", 32'(outs()), 32'h0);
        @(posedge iClk);
        @(posedge iClk);
        #3;
        iRst = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check($sformatf("rst_held_c%0d", j), 32'(outs()), 32'h0);
        end
        iBtn_Mode = 1'b0; iBtn_Up = 1'b0; tick();
        iBtn_Mode = 1'b1; tick();
        check("rst_repress", 32'({oMode, oSet}), 32'({2'b01, 1'b1}));
        iBtn_Mode = 1'b0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
